// File: rtl/fpu_share_arbiter_if.sv
// Request/response and FPU-side signal bundle for fpu_share_arbiter.
// slave: the arbiter's view. master: the requesters and the FPU.
interface fpu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid_0;
  logic [1:0]       req_op_0;
  logic [WIDTH-1:0] req_a_0;
  logic [WIDTH-1:0] req_b_0;
  logic             req_ready_0;
  logic             resp_valid_0;
  logic [WIDTH-1:0] resp_result_0;
  logic             resp_error_0;

  logic             req_valid_1;
  logic [1:0]       req_op_1;
  logic [WIDTH-1:0] req_a_1;
  logic [WIDTH-1:0] req_b_1;
  logic             req_ready_1;
  logic             resp_valid_1;
  logic [WIDTH-1:0] resp_result_1;
  logic             resp_error_1;

  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;

  modport slave (
    input  req_valid_0, req_op_0, req_a_0, req_b_0,
    output req_ready_0, resp_valid_0, resp_result_0, resp_error_0,
    input  req_valid_1, req_op_1, req_a_1, req_b_1,
    output req_ready_1, resp_valid_1, resp_result_1, resp_error_1,
    output fpu_operand_1, fpu_operand_2, fpu_operation,
    input  fpu_result, fpu_ready
  );

  modport master (
    output req_valid_0, req_op_0, req_a_0, req_b_0,
    input  req_ready_0, resp_valid_0, resp_result_0, resp_error_0,
    output req_valid_1, req_op_1, req_a_1, req_b_1,
    input  req_ready_1, resp_valid_1, resp_result_1, resp_error_1,
    input  fpu_operand_1, fpu_operand_2, fpu_operation,
    output fpu_result, fpu_ready
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one Fixed_Point_Unit between the execute stage
// (requester 0) and the coprocessor port (requester 1). One operation in
// flight; operands held on the FPU until it answers or the timeout fires.
module fpu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_share_arbiter_if.slave   bus,
  output logic                 busy
);

  localparam logic [1:0] FPU_ADD  = 2'b00;
  localparam logic [1:0] FPU_SUB  = 2'b01;
  localparam logic [1:0] FPU_MUL  = 2'b10;
  localparam logic [1:0] FPU_SQRT = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             error_q;
  logic             resp_valid_q;
  logic [7:0]       tcount;

  logic any_valid;
  logic grant_sel;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_valid = bus.req_valid_0 | bus.req_valid_1;
    grant_sel = (bus.req_valid_0 & bus.req_valid_1) ? ~last_grant : bus.req_valid_1;
  end

  // Ready is combinational in IDLE; the response pulse is masked while reset
  // is asserted so a response caught in RESP never reaches a requester.
  assign bus.req_ready_0   = (state == IDLE) & ~reset & any_valid & ~grant_sel;
  assign bus.req_ready_1   = (state == IDLE) & ~reset & any_valid &  grant_sel;
  assign bus.resp_valid_0  = resp_valid_q & ~grant_id & ~reset;
  assign bus.resp_valid_1  = resp_valid_q &  grant_id & ~reset;
  assign bus.resp_error_0  = error_q & ~grant_id;
  assign bus.resp_error_1  = error_q &  grant_id;
  assign bus.resp_result_0 = result_q;
  assign bus.resp_result_1 = result_q;
  assign bus.fpu_operand_1 = a_q;
  assign bus.fpu_operand_2 = b_q;
  assign bus.fpu_operation = op_q;
  assign busy              = (state != IDLE);

  // Control FSM; op/a/b registers double as the FPU drive and are zeroed
  // (op=ADD) outside ISSUE/WAIT to keep the multiply sequencer parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      op_q         <= FPU_ADD;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      error_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      tcount       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            op_q       <= grant_sel ? bus.req_op_1 : bus.req_op_0;
            a_q        <= grant_sel ? bus.req_a_1  : bus.req_a_0;
            b_q        <= grant_sel ? bus.req_b_1  : bus.req_b_0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          tcount <= '0;
          case (op_q)
            FPU_ADD, FPU_SUB: begin
              result_q     <= bus.fpu_result;
              error_q      <= 1'b0;
              resp_valid_q <= 1'b1;
              op_q         <= FPU_ADD;
              a_q          <= '0;
              b_q          <= '0;
              state        <= RESP;
            end
            FPU_MUL, FPU_SQRT: state <= WAIT;
            default:           state <= WAIT;
          endcase
        end
        WAIT: begin
          if (bus.fpu_ready) begin
            result_q     <= bus.fpu_result;
            error_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            op_q         <= FPU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            state        <= RESP;
          end else if (tcount == 8'(TIMEOUT - 1)) begin
            result_q     <= '0;
            error_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            op_q         <= FPU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            state        <= RESP;
          end else begin
            tcount <= tcount + 8'd1;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          error_q      <= 1'b0;
          result_q     <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Scoreboard bench for fpu_share_arbiter with a behavioural FPU model whose
// ready timing is programmed per test.
module tb_fpu_share_arbiter;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;
  localparam logic [31:0] SQRT_RES = 32'h0000_05A8;

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  int   rdy_delay;
  logic stale;
  int   mcnt;

  logic [31:0] pa   [2][2] = '{'{32'h0000_0400, 32'h0000_1000}, '{32'h0000_0A00, 32'hFFFF_FC00}};
  logic [31:0] pb   [2][2] = '{'{32'h0000_0200, 32'h0000_0001}, '{32'h0000_0600, 32'h0000_0800}};
  logic [31:0] pexp [2][2] = '{'{32'h0000_0600, 32'h0000_1001}, '{32'h0000_1000, 32'h0000_0400}};

  fpu_share_arbiter_if #(.WIDTH(32)) bus ();

  fpu_share_arbiter #(.WIDTH(32), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FPU model: Q.10 arithmetic; ready pulses on the programmed WAIT cycle.
  logic mulsqrt;
  always_comb begin
    mulsqrt = (bus.fpu_operation == OP_MUL) || (bus.fpu_operation == OP_SQRT);
    case (bus.fpu_operation)
      OP_ADD:  bus.fpu_result = bus.fpu_operand_1 + bus.fpu_operand_2;
      OP_SUB:  bus.fpu_result = bus.fpu_operand_1 - bus.fpu_operand_2;
      OP_MUL:  bus.fpu_result = 32'((64'(bus.fpu_operand_1) * 64'(bus.fpu_operand_2)) >> 10);
      default: bus.fpu_result = SQRT_RES;
    endcase
    bus.fpu_ready = mulsqrt && (((rdy_delay != 0) && (mcnt == rdy_delay)) || (stale && (mcnt == 0)));
  end

  always @(posedge clk) mcnt <= mulsqrt ? mcnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req_ready_0 : bus.req_ready_1;
  endfunction

  task automatic drive(input int p, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req_valid_0 = v; bus.req_op_0 = op; bus.req_a_0 = a; bus.req_b_0 = b;
    end else begin
      bus.req_valid_1 = v; bus.req_op_1 = op; bus.req_a_1 = a; bus.req_b_1 = b;
    end
  endtask

  // Monitor: every response pulse pops one expectation (port, data, error, edge).
  always @(negedge clk) begin
    exp_t        e;
    logic        v;
    logic [31:0] r;
    logic        er;
    for (int p = 0; p < 2; p++) begin
      v  = (p == 0) ? bus.resp_valid_0  : bus.resp_valid_1;
      r  = (p == 0) ? bus.resp_result_0 : bus.resp_result_1;
      er = (p == 0) ? bus.resp_error_0  : bus.resp_error_1;
      if (v === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_resp: got resp_valid on port %0d, expected none (cycle %0d)", p, cyc);
        end else begin
          e = sb.pop_front();
          check("resp_port",   32'(p),       32'(e.port));
          check("resp_result", r,            e.result);
          check("resp_error",  32'(er),      32'(e.err));
          check("resp_edge",   32'(cyc + 1), 32'(e.cyc));
        end
      end
    end
  end

  // Single request; latency counts accept edge to the edge sampling resp_valid.
  task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_err, input int lat);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    drive(p, 1'b1, op, a, b);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rdy(p) === 1'b1) begin
        got      = 1'b1;
        e.port   = p;
        e.result = exp_res;
        e.err    = exp_err;
        e.cyc    = cyc + 1 + lat;
        sb.push_back(e);
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no req_ready on port %0d, expected one", p);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, OP_ADD, '0, '0);
  endtask

  task automatic requester(input int p, input int n);
    int k;
    k = 0;
    drive(p, 1'b1, OP_ADD, pa[p][0], pb[p][0]);
    for (int i = 0; i < 80 && k < n; i++) begin
      @(negedge clk);
      if (rdy(p) === 1'b1) begin
        k++;
        @(posedge clk); #1;
        if (k < n) drive(p, 1'b1, OP_ADD, pa[p][k], pb[p][k]);
        else       drive(p, 1'b0, OP_ADD, '0, '0);
      end
    end
    if (k < n) begin
      vectors++;
      miscompares++;
      $display("FAIL pair_accept_timeout: got %0d accepts on port %0d, expected %0d", k, p, n);
      drive(p, 1'b0, OP_ADD, '0, '0);
    end
  endtask

  // Both requesters valid from the same cycle: grants 0,1,0,1 three edges apart.
  task automatic pair_run(input int n);
    exp_t e;
    int   a0;
    @(posedge clk); #1;
    a0 = cyc + 1;
    for (int k = 0; k < n; k++) begin
      e.port = 0; e.result = pexp[0][k]; e.err = 1'b0; e.cyc = a0 + 6 * k + 2;
      sb.push_back(e);
      e.port = 1; e.result = pexp[1][k]; e.err = 1'b0; e.cyc = a0 + 6 * k + 5;
      sb.push_back(e);
    end
    fork
      requester(0, n);
      requester(1, n);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    rdy_delay = 0; stale = 1'b0;
    reset = 1'b1;
    drive(0, 1'b0, OP_ADD, '0, '0);
    drive(1, 1'b0, OP_ADD, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy",      32'(busy),              32'd0);
    check("rst_ready_0",   32'(bus.req_ready_0),   32'd0);
    check("rst_ready_1",   32'(bus.req_ready_1),   32'd0);
    check("rst_rvalid_0",  32'(bus.resp_valid_0),  32'd0);
    check("rst_rvalid_1",  32'(bus.resp_valid_1),  32'd0);
    check("rst_rerror_0",  32'(bus.resp_error_0),  32'd0);
    check("rst_result_0",  bus.resp_result_0,      32'd0);
    check("rst_fpu_op",    32'(bus.fpu_operation), 32'd0);
    check("rst_fpu_a",     bus.fpu_operand_1,      32'd0);
    check("rst_fpu_b",     bus.fpu_operand_2,      32'd0);

    // Fairness straight from reset: requester 0 wins the first tie.
    pair_run(2);

    // ADD 1.5 + 2.0, busy for exactly the ISSUE and RESP cycles.
    issue(0, OP_ADD, 32'h0000_0600, 32'h0000_0800, 32'h0000_0E00, 1'b0, 2);
    @(negedge clk); check("add_busy_issue", 32'(busy), 32'd1);
    @(negedge clk); check("add_busy_resp",  32'(busy), 32'd1);
    @(negedge clk); check("add_busy_idle",  32'(busy), 32'd0);

    // MUL 1.5 * 2.0 with ready 5 cycles into WAIT; FPU inputs held throughout.
    rdy_delay = 5;
    issue(1, OP_MUL, 32'h0000_0600, 32'h0000_0800, 32'h0000_0C00, 1'b0, 7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mul_hold_a",  bus.fpu_operand_1,      32'h0000_0600);
      check("mul_hold_b",  bus.fpu_operand_2,      32'h0000_0800);
      check("mul_hold_op", 32'(bus.fpu_operation), 32'(OP_MUL));
    end
    repeat (4) @(posedge clk);

    rdy_delay = 0;
    issue(1, OP_SUB, 32'h0000_0800, 32'h0000_0600, 32'h0000_0200, 1'b0, 2);
    repeat (3) @(posedge clk);

    // SQRT timeout with ready stuck low, then ready one cycle early and on the last cycle.
    issue(0, OP_SQRT, 32'h0000_0800, 32'h0, 32'h0, 1'b1, 66);
    repeat (70) @(posedge clk);
    rdy_delay = 63;
    issue(0, OP_SQRT, 32'h0000_0800, 32'h0, SQRT_RES, 1'b0, 65);
    repeat (70) @(posedge clk);
    rdy_delay = 64;
    issue(1, OP_SQRT, 32'h0000_0800, 32'h0, SQRT_RES, 1'b0, 66);
    repeat (70) @(posedge clk);

    // Stale ready during ISSUE must be ignored; capture on WAIT cycle 4.
    rdy_delay = 4; stale = 1'b1;
    issue(0, OP_MUL, 32'h0000_0600, 32'h0000_0800, 32'h0000_0C00, 1'b0, 6);
    repeat (10) @(posedge clk);
    stale = 1'b0; rdy_delay = 0;

    // Reset in WAIT of a requester-0 MUL: no response, idle next cycle.
    begin
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      drive(0, 1'b1, OP_MUL, 32'h0000_0600, 32'h0000_0800);
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus.req_ready_0 === 1'b1) got = 1'b1;
      end
      check("rstmid_accept", 32'(got), 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, OP_ADD, '0, '0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rstmid_busy",     32'(busy),              32'd0);
      check("rstmid_fpu_op",   32'(bus.fpu_operation), 32'd0);
      check("rstmid_fpu_a",    bus.fpu_operand_1,      32'd0);
      check("rstmid_rvalid_0", 32'(bus.resp_valid_0), 32'd0);
    end
    repeat (3) @(posedge clk);
    pair_run(1);

    repeat (10) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one Fixed_Point_Unit instance between two requesters: requester 0 is the core execute stage, requester 1 is the coprocessor/accelerator port.
- Round-robin arbitration, one operation in flight at a time.
- Latches the operands and keeps them stable on the FPU inputs until the unit signals ready.
- Returns a one-cycle tagged response to the granted requester, and breaks hung multi-cycle operations with a timeout.

Parameters:
- WIDTH, 32, operand/result width; matches the FPU WIDTH.
- TIMEOUT, 64, WAIT cycles allowed for MUL/SQRT before an error response; legal range 2..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid_0  input  1  requester 0 has an operation
- req_op_0  input  2  operation code (`FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT from Defines.vh)
- req_a_0  input  WIDTH  operand 1
- req_b_0  input  WIDTH  operand 2
- req_ready_0  output  1  requester 0 accepted this cycle
- resp_valid_0  output  1  response to requester 0, one-cycle pulse
- resp_result_0  output  WIDTH  result
- resp_error_0  output  1  timeout flag, qualified by resp_valid_0
- req_valid_1, req_op_1, req_a_1, req_b_1, req_ready_1, resp_valid_1, resp_result_1, resp_error_1: same as the _0 set, for requester 1
- fpu_operand_1  output  WIDTH  to FPU operand_1
- fpu_operand_2  output  WIDTH  to FPU operand_2
- fpu_operation  output  2  to FPU operation
- fpu_result  input  WIDTH  from FPU result
- fpu_ready  input  1  from FPU ready
- busy  output  1  high in every state except IDLE

Behaviour:
- Clocking: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE; all req_ready/resp_valid/resp_error=0; resp_result=0; fpu_operation=`FPU_ADD; fpu operands=0; last_grant=1 (requester 0 wins the first tie); timeout counter=0.
- State machine: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
- IDLE:
  - fpu_operation=`FPU_ADD, operands 0; fpu_ready ignored. This keeps the FPU multiply sequencer parked.
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - req_ready_g is asserted combinationally in the same cycle.
  - On the grant edge: latch op, a, b and grant id; update last_grant; go to ISSUE.
  - req_ready is never high outside IDLE. Requesters hold valid and payload until ready.
- ISSUE:
  - Drive fpu_* from the latched registers; clear the timeout counter.
  - ADD/SUB: capture fpu_result into the response register (error=0); go to RESP.
  - MUL/SQRT: fpu_ready is ignored in this cycle (it may be stale from a prior op); go to WAIT.
- WAIT:
  - Drive the same fpu_* values; counter increments each cycle.
  - fpu_ready=1: capture fpu_result, error=0, go to RESP.
  - Otherwise, when counter reaches TIMEOUT-1: result=0, error=1, go to RESP.
  - fpu_ready wins if it coincides with the timeout cycle.
- RESP:
  - resp_valid_g=1 for exactly one cycle, with resp_result_g and resp_error_g. The other requester's resp_valid stays 0.
  - fpu_* return to idle values; go to IDLE.
- Responses have no backpressure.
- Latency, accept edge to resp_valid:
  - ADD/SUB: exactly 2 cycles.
  - MUL/SQRT: 2 + N cycles, where N = WAIT cycles until ready.
  - Minimum gap between back-to-back accepts: 3 cycles.
- Starvation: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- A requester dropping valid before it is granted is legal; it causes no grant and no response.
- Reset mid-operation (ISSUE/WAIT/RESP): the operation is abandoned with no response pulse and all outputs return to reset values on the next edge. A response already in RESP is suppressed.
- Arithmetic: no width conversion; results pass through unmodified. The fixed-point format (FBITS) belongs to the FPU.
- Undefined op codes are impossible with a 2-bit field; all four are legal.

Test Plan:
- ADD: requester 0 sends op=ADD, a=0x600 (1.5, FBITS=10), b=0x800 (2.0) -> req_ready_0 in the accept cycle; resp_valid_0 exactly 2 cycles later with result 0x00000E00, error=0; busy high for 2 cycles.
- MUL via model: requester 1 sends MUL 0x600 x 0x800; FPU model raises ready 5 cycles into WAIT with 0xC00 -> resp_valid_1 with 0x00000C00 at accept+7; fpu_operand_1/2 and fpu_operation stable for the whole operation.
- Fairness: both requesters hold valid ADD continuously from reset -> grants go 0,1,0,1; accept edges 3 cycles apart; each response appears only on the owning port.
- Timeout: SQRT issued with FPU model ready stuck at 0, TIMEOUT=64 -> resp_valid with result 0 and error=1 after 64 WAIT cycles. A second run raising ready on the final WAIT cycle -> error=0 with the model result.
- Stale ready: FPU model holds ready=1 during ISSUE of a MUL, then drops it for 3 cycles -> no early response; result captured on the later ready.
- Reset during WAIT of a MUL from requester 0 -> no resp_valid on either port; busy=0 on the next cycle; the next simultaneous request pair grants requester 0 first.
